soc_gpio: RTL and testbench
===========================

# soc_gpio

Parametrised general-purpose I/O peripheral replacing the single write-only output pin in the SoC top level. Provides WIDTH bidirectional pins with per-pin direction, atomic set/clear/toggle, synchronised input read-back and rising-edge interrupts. Sits on the registered CPU_BusMux bus as a chip-selected slave, with the same request/ready handshake as BRAM and SoC_BROM.

## Interface
- WIDTH, 8: pin count, 1..32.
- SYNC_STAGES, 2: input synchroniser depth, ≥2.
- RESET_OUT, 0: WIDTH-bit output value loaded at reset.
- i_clock  in  1  system clock; all logic on posedge.
- i_reset  in  1  synchronous, active-low reset.
- i_request  in  1  access request, already qualified by chip select; held until o_ready.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  32  byte address; only [4:2] decoded.
- i_wdata  in  32  write data; bits ≥ WIDTH ignored.
- o_rdata  out  32  read data; valid only while o_ready=1.
- o_ready  out  1  one-cycle access-complete pulse.
- i_pins  in  WIDTH  asynchronous pin inputs.
- o_pins  out  WIDTH  registered output values.
- o_oe  out  WIDTH  output enables, 1 = drive.
- o_interrupt  out  1  level interrupt, registered.

## Operation
- Register map (i_address[4:2]):
  - 0 OUT: R/W output register.
  - 1 IN: R, synchronised pin state; writes ignored.
  - 2 DIR: R/W, 1 = output; o_oe = DIR.
  - 3 SET: W, OUT |= wdata; reads 0.
  - 4 CLR: W, OUT &= ~wdata; reads 0.
  - 5 TGL: W, OUT ^= wdata; reads 0.
  - 6 IEN: R/W rising-edge interrupt enable.
  - 7 IST: R status; write-1-to-clear.
- Unimplemented bits ≥ WIDTH read 0.
- Handshake: an access is accepted when i_request=1 and o_ready=0. The register effect and o_ready=1 occur on the next edge. o_ready is high for exactly one cycle. A request still held during the o_ready cycle is not re-accepted.
- Input path: i_pins passes through a SYNC_STAGES flop chain to IN, then one further flop, prev.
  - edge = IN & ~prev & ~DIR. Edges are detected on input-direction pins only.
- IST bit sets on an edge regardless of IEN. o_interrupt <= |(IST & IEN).
- Arm counter: after reset release, edge detection is suppressed for SYNC_STAGES+1 cycles. This prevents spurious edges from pins already high at reset.
- Simultaneous events:
  - An edge arriving in the same cycle as a W1C of the same IST bit leaves the bit set (set wins).
  - A DIR change to output masks edges starting the next cycle.
- Reset (i_reset=0), all synchronous:
  - OUT = RESET_OUT; DIR = 0; IEN = 0; IST = 0.
  - Sync chain and prev = 0; arm counter restarts.
  - o_ready = 0, o_rdata = 0, o_interrupt = 0.
  - An access in flight is dropped with no o_ready. The master re-issues the access after reset.

## Timing
- Write latency: request seen at edge N gives o_ready=1 and the updated register/o_pins after edge N+1.
- Read latency: same. o_rdata is sampled at edge N+1 and is 0 when o_ready=0.
- Input latency: a pin change before edge K appears in IN after edge K+SYNC_STAGES-1.
  - IST sets after edge K+SYNC_STAGES.
  - o_interrupt rises after edge K+SYNC_STAGES+1.
- Back-to-back accesses complete every 2 cycles at most. The registered mux naturally inserts gaps.

## Test plan
- Reset with RESET_OUT=8'hA5, i_pins=8'hFF held: o_pins=A5, o_oe=00, IST=00 and o_interrupt=0 for 20 cycles after release (arm counter suppresses edges).
- Write OUT=0x0F, SET 0xF0, CLR 0x03, TGL 0x81 → o_pins 0F, FF, FC, 7D. Each o_ready is a single pulse one cycle after the request; reads of SET/CLR/TGL return 0.
- DIR=0x0F, IEN=0x10, raise i_pins[4] → IST=0x10 after SYNC_STAGES+1 edges and o_interrupt=1 one cycle later. Raise i_pins[0] (output pin) → no IST change.
- W1C IST=0x10 in the same cycle as a new rising edge on pin 4 → IST stays 0x10. A later W1C with no edge → IST=0, then o_interrupt=0 one cycle later.
- Read IN with i_pins=0x3C stable → o_rdata=0x0000003C only in the o_ready cycle and 0 otherwise. Hold i_request through the o_ready cycle → no second o_ready in the following cycle.
- Assert reset mid-write, between request and o_ready → no o_ready, OUT=RESET_OUT. Re-issued write completes normally.

Source files
------------

// File: rtl/soc_gpio.sv
// WIDTH-pin GPIO bus slave: direction, atomic set/clear/toggle, synchronised input read-back
// and rising-edge interrupts with write-1-to-clear status.
module soc_gpio #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_request,
    input  logic             i_rw,
    input  logic [31:0]      i_address,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_pins,
    output logic [WIDTH-1:0] o_oe,
    output logic             o_interrupt
);
    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_CYCLES[ARM_W-1:0];

    typedef enum logic [2:0] {
        REG_OUT = 3'd0, REG_IN  = 3'd1, REG_DIR = 3'd2, REG_SET = 3'd3,
        REG_CLR = 3'd4, REG_TGL = 3'd5, REG_IEN = 3'd6, REG_IST = 3'd7
    } reg_sel_e;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [ARM_W-1:0] r_arm;
    logic [WIDTH-1:0] r_out, r_dir, r_ien, r_ist;
    logic             r_ready, r_interrupt;
    logic [31:0]      r_rdata;

    logic             w_accept, w_write, w_armed;
    reg_sel_e         w_sel;
    logic [WIDTH-1:0] w_in, w_wd, w_edge, w_w1c, w_rd_sel;
    logic [WIDTH-1:0] w_out_next, w_dir_next, w_ien_next;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_sel    = reg_sel_e'(i_address[4:2]);
    assign w_accept = i_request & ~r_ready;
    assign w_write  = w_accept & i_rw;
    assign w_wd     = i_wdata[WIDTH-1:0];
    assign w_in     = r_sync[SYNC_STAGES-1];
    assign w_armed  = (r_arm == ARM_DONE);
    assign w_edge   = w_armed ? (w_in & ~r_prev & ~r_dir) : '0;
    assign w_unused = ^{i_address[31:5], i_address[1:0], i_wdata};

    // Next-state of the writable registers for the access being accepted this cycle
    always_comb begin
        w_out_next = r_out;
        w_dir_next = r_dir;
        w_ien_next = r_ien;
        w_w1c      = '0;
        if (w_write) begin
            case (w_sel)
                REG_OUT: w_out_next = w_wd;
                REG_DIR: w_dir_next = w_wd;
                REG_SET: w_out_next = r_out | w_wd;
                REG_CLR: w_out_next = r_out & ~w_wd;
                REG_TGL: w_out_next = r_out ^ w_wd;
                REG_IEN: w_ien_next = w_wd;
                REG_IST: w_w1c      = w_wd;
                default: w_w1c      = '0;
            endcase
        end else begin
            w_w1c = '0;
        end
    end

    // Read mux; write-only and unimplemented locations return zero
    always_comb begin
        w_rdata = 32'd0;
        case (w_sel)
            REG_OUT: w_rd_sel = r_out;
            REG_IN:  w_rd_sel = w_in;
            REG_DIR: w_rd_sel = r_dir;
            REG_IEN: w_rd_sel = r_ien;
            REG_IST: w_rd_sel = r_ist;
            default: w_rd_sel = '0;
        endcase
        w_rdata[WIDTH-1:0] = w_rd_sel;
    end

    // Pin synchroniser, edge-history flop and post-reset arm counter
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
            r_prev <= '0;
            r_arm  <= '0;
        end else begin
            r_sync[0] <= i_pins;
            for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_in;
            if (!w_armed) r_arm <= r_arm + ARM_W'(1);
            else          r_arm <= r_arm;
        end
    end

    // Register file, handshake and interrupt; a fresh edge beats a same-cycle W1C
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_out       <= RESET_OUT;
            r_dir       <= '0;
            r_ien       <= '0;
            r_ist       <= '0;
            r_ready     <= 1'b0;
            r_rdata     <= 32'd0;
            r_interrupt <= 1'b0;
        end else begin
            r_out       <= w_out_next;
            r_dir       <= w_dir_next;
            r_ien       <= w_ien_next;
            r_ist       <= (r_ist & ~w_w1c) | w_edge;
            r_ready     <= w_accept;
            r_rdata     <= (w_accept && !i_rw) ? w_rdata : 32'd0;
            r_interrupt <= |(r_ist & r_ien);
        end
    end

    assign o_rdata     = r_rdata;
    assign o_ready     = r_ready;
    assign o_pins      = r_out;
    assign o_oe        = r_dir;
    assign o_interrupt = r_interrupt;
endmodule

// File: tb/tb_soc_gpio.sv
// Randomised + directed bench for soc_gpio against a cycle-level behavioural model that
// tracks pin history as a sample queue and applies the register rules directly.
module tb_soc_gpio;
    localparam int S = 2;
    localparam logic [7:0] RST_OUT = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, rw = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready, irq;
    logic [7:0]  pins = 8'h00, opins, oe;

    int checks = 0;
    int errors = 0;

    soc_gpio #(.WIDTH(8), .SYNC_STAGES(S), .RESET_OUT(RST_OUT)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_request(req), .i_rw(rw),
        .i_address(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ready(ready),
        .i_pins(pins), .o_pins(opins), .o_oe(oe), .o_interrupt(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_out, m_dir, m_ien, m_ist;
    logic        m_ready, m_irq;
    logic [31:0] m_rdata;
    logic [7:0]  hist [0:S];   // hist[0] = pins sampled at the most recent edge
    int          since_rel;
    bit          started = 1'b0;

    always @(posedge clk) begin
        logic [7:0] in_v, edg, w1c, wd, rd8;
        logic       acc, nirq;
        started = 1'b1;
        if (!rst_n) begin
            m_out = RST_OUT; m_dir = 8'h00; m_ien = 8'h00; m_ist = 8'h00;
            m_ready = 1'b0; m_irq = 1'b0; m_rdata = 32'd0;
            for (int i = 0; i <= S; i++) hist[i] = 8'h00;
            since_rel = 0;
        end else begin
            in_v = hist[S-1];
            edg  = (since_rel > S) ? (in_v & ~hist[S] & ~m_dir) : 8'h00;
            acc  = req && !m_ready;
            nirq = |(m_ist & m_ien);
            wd   = wdata[7:0];
            w1c  = 8'h00;
            rd8  = 8'h00;
            if (acc && rw) begin
                case (addr[4:2])
                    3'd0: m_out = wd;
                    3'd2: m_dir = wd;
                    3'd3: m_out = m_out | wd;
                    3'd4: m_out = m_out & ~wd;
                    3'd5: m_out = m_out ^ wd;
                    3'd6: m_ien = wd;
                    3'd7: w1c = wd;
                    default: w1c = 8'h00;
                endcase
            end else if (acc) begin
                case (addr[4:2])
                    3'd0: rd8 = m_out;
                    3'd1: rd8 = in_v;
                    3'd2: rd8 = m_dir;
                    3'd6: rd8 = m_ien;
                    3'd7: rd8 = m_ist;
                    default: rd8 = 8'h00;
                endcase
            end
            m_ist   = (m_ist & ~w1c) | edg;
            m_ready = acc;
            m_rdata = {24'd0, rd8};
            m_irq   = nirq;
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = pins;
            if (since_rel < 1000) since_rel++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            check("ready", {31'd0, ready}, {31'd0, m_ready});
            check("rdata", rdata, m_rdata);
            check("pins",  {24'd0, opins}, {24'd0, m_out});
            check("oe",    {24'd0, oe}, {24'd0, m_dir});
            check("irq",   {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d,
                          input bit hold, output logic [31:0] rd);
        bit seen;
        seen = 1'b0;
        rd = 32'd0;
        @(posedge clk); #2;
        req = 1'b1; rw = w; addr = {27'd0, a, 2'b00}; wdata = d;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(posedge clk); #1;
            if (ready) begin seen = 1'b1; rd = rdata; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got no o_ready expected pulse at %0t", $time);
        end
        if (hold) begin
            @(posedge clk); #1;
            check("no_reaccept", {31'd0, ready}, 32'd0);
        end
        #1 req = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        access(1'b1, a, d, 1'b0, dummy);
    endtask

    task automatic rd_expect(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        access(1'b0, a, 32'd0, 1'b0, v);
        check(name, v, exp);
    endtask

    task automatic set_pins(input logic [7:0] v, input int settle);
        @(posedge clk); #2 pins = v;
        repeat (settle) @(posedge clk);
    endtask

    initial begin
        logic [31:0] v;
        // Reset with all pins high: arm counter must suppress the would-be edges
        pins = 8'hFF;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 0 || i == 19) begin
                check("rst_pins", {24'd0, opins}, 32'h0000_00A5);
                check("rst_irq",  {31'd0, irq}, 32'd0);
            end
        end
        rd_expect("rst_ist", 3'd7, 32'd0);

        // Atomic output operations
        wr(3'd0, 32'h0000_000F); check("out_wr",  {24'd0, opins}, 32'h0F);
        wr(3'd3, 32'hFFFF_FFF0); check("out_set", {24'd0, opins}, 32'hFF);
        wr(3'd4, 32'h0000_0003); check("out_clr", {24'd0, opins}, 32'hFC);
        wr(3'd5, 32'h0000_0081); check("out_tgl", {24'd0, opins}, 32'h7D);
        rd_expect("rd_set", 3'd3, 32'd0);
        rd_expect("rd_clr", 3'd4, 32'd0);
        rd_expect("rd_tgl", 3'd5, 32'd0);
        rd_expect("rd_out", 3'd0, 32'h7D);

        // Rising edge on input pin 4 raises IST and then the interrupt
        set_pins(8'h00, 5);
        wr(3'd2, 32'h0000_000F);
        wr(3'd6, 32'h0000_0010);
        @(posedge clk); #2 pins = 8'h10;
        repeat (3) @(posedge clk); #1;
        check("irq_early", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_rise", {31'd0, irq}, 32'd1);
        rd_expect("ist_set", 3'd7, 32'h10);
        set_pins(8'h11, 5);
        rd_expect("ist_outpin", 3'd7, 32'h10);

        // W1C colliding with a fresh edge on the same bit: set wins
        set_pins(8'h01, 5);
        @(posedge clk); #2 pins = 8'h11;
        @(posedge clk);
        wr(3'd7, 32'h0000_0010);
        rd_expect("ist_setwins", 3'd7, 32'h10);
        wr(3'd7, 32'h0000_0010);
        rd_expect("ist_clr", 3'd7, 32'd0);
        check("irq_fall", {31'd0, irq}, 32'd0);

        // IN read-back and held request
        set_pins(8'h3C, 4);
        rd_expect("rd_in", 3'd1, 32'h3C);
        access(1'b0, 3'd1, 32'd0, 1'b1, v);
        check("rd_in_hold", v, 32'h3C);

        // Reset during an in-flight write, then re-issue
        @(posedge clk); #2;
        req = 1'b1; rw = 1'b1; addr = 32'd0; wdata = 32'h55; rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_drop_ready", {31'd0, ready}, 32'd0);
        check("rst_drop_pins", {24'd0, opins}, 32'hA5);
        #1 req = 1'b0; rst_n = 1'b1;
        wr(3'd0, 32'h55); check("reissue", {24'd0, opins}, 32'h55);

        // Randomised traffic checked every cycle by the model
        for (int it = 0; it < 400; it++) begin
            int kind;
            kind = $urandom_range(0, 99);
            if (kind < 30) begin
                @(posedge clk); #2 pins = 8'($urandom);
            end else if (kind < 32) begin
                @(posedge clk); #2 rst_n = 1'b0;
                @(posedge clk); #2 rst_n = 1'b1;
            end else begin
                access(1'($urandom), 3'($urandom), $urandom, 1'($urandom_range(0, 3) == 0), v);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
